// File: rtl/seg7_scan_decoder.sv
// Reads a multiplexed active-low seven-segment bus and recovers the code on each digit position.
// Inputs are synchronised, debounced by a stability counter, reverse-decoded and framed over valid/ready.
module seg7_scan_decoder #(
  parameter int NDIG   = 4,
  parameter int STABLE = 8
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [0:6]          Seg,
  input  logic [NDIG-1:0]     Dig,
  output logic [4*NDIG-1:0]   Digits,
  output logic                Upd,
  output logic [2:0]          Upd_idx,
  output logic [3:0]          Upd_code,
  output logic [4*NDIG-1:0]   Frame,
  output logic                Frame_valid,
  input  logic                Frame_ready,
  output logic                Err,
  output logic                Overrun,
  input  logic                Flag_clr
);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  localparam logic [7:0]          CNT_MAX   = 8'(STABLE);
  localparam logic [7:0]          CNT_LAST  = 8'(STABLE - 1);
  localparam logic [NDIG-1:0]     MASK_FULL = {NDIG{1'b1}};
  localparam logic [4*NDIG-1:0]   ALL_BLANK = {NDIG{4'hE}};

  // Descending copy of the segment bus; bit 6 is segment a, bit 0 is segment g.
  logic [6:0] seg_in;
  assign seg_in = Seg;

  logic [6:0]        seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_prev_q, seg_prev_d;
  logic [NDIG-1:0]   dig_s1_q, dig_s1_d, dig_s2_q, dig_s2_d, dig_prev_q, dig_prev_d;
  logic [7:0]        cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic [NDIG-1:0]   mask_q, mask_d;
  logic [4*NDIG-1:0] digits_q, digits_d;
  logic [4*NDIG-1:0] frame_q, frame_d;
  logic              frame_valid_q, frame_valid_d;
  logic              upd_q, upd_d;
  logic [2:0]        upd_idx_q, upd_idx_d;
  logic [3:0]        upd_code_q, upd_code_d;
  logic              err_q, err_d;
  logic              overrun_q, overrun_d;

  logic              changed;
  logic              one_hot;
  logic [3:0]        low_cnt;
  logic [2:0]        pos;
  logic [3:0]        code;
  logic              capture;
  logic              accept;
  logic              complete;
  logic              overrun_set;

  // Synchroniser chain plus the one-cycle-delayed copy used for change detection.
  always_comb begin
    seg_s1_d   = seg_in;
    seg_s2_d   = seg_s1_q;
    seg_prev_d = seg_s2_q;
    dig_s1_d   = Dig;
    dig_s2_d   = dig_s1_q;
    dig_prev_d = dig_s2_q;
  end

  always_comb begin
    changed = (seg_s2_q != seg_prev_q) || (dig_s2_q != dig_prev_q);
    low_cnt = 4'd0;
    pos     = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (!dig_s2_q[i]) begin
        low_cnt = low_cnt + 4'd1;
        pos     = 3'(i);
      end
    end
    one_hot = (low_cnt == 4'd1);
  end

  always_comb begin
    case (seg_s2_q)
      7'b0000001: code = 4'h0;
      7'b1001111: code = 4'h1;
      7'b0010010: code = 4'h2;
      7'b0000110: code = 4'h3;
      7'b1001100: code = 4'h4;
      7'b0100100: code = 4'h5;
      7'b0100000: code = 4'h6;
      7'b0001111: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0000100: code = 4'h9;
      7'b0001000: code = 4'hA;
      7'b1111111: code = 4'hE;
      default:    code = 4'hF;
    endcase
  end

  // Stability counter and capture FSM.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    capture = 1'b0;
    if (changed) begin
      cnt_d   = 8'd0;
      state_d = one_hot ? SETTLE : IDLE;
    end else begin
      if (cnt_q < CNT_MAX) begin
        cnt_d = cnt_q + 8'd1;
      end
      if (state_q == SETTLE && cnt_q == CNT_LAST) begin
        capture = 1'b1;
        state_d = LOCKED;
      end
    end
  end

  always_comb begin
    digits_d      = digits_q;
    mask_d        = mask_q;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;
    upd_d         = capture;
    upd_idx_d     = upd_idx_q;
    upd_code_d    = upd_code_q;
    err_d         = err_q;
    overrun_d     = overrun_q;
    overrun_set   = 1'b0;
    accept        = frame_valid_q & Frame_ready;

    if (capture) begin
      upd_idx_d  = pos;
      upd_code_d = code;
      for (int i = 0; i < NDIG; i++) begin
        if (pos == 3'(i)) begin
          digits_d[4*i +: 4] = code;
          mask_d[i]          = 1'b1;
        end
      end
    end

    if (accept) begin
      frame_valid_d = 1'b0;
    end

    // An accept in the completion cycle frees the slot, so the new frame loads without overrun.
    complete = capture && (mask_d == MASK_FULL);
    if (complete) begin
      mask_d = '0;
      if (!frame_valid_q || accept) begin
        frame_d       = digits_d;
        frame_valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end

    if (Flag_clr) begin
      err_d     = 1'b0;
      overrun_d = 1'b0;
    end
    if (capture && code == 4'hF) begin
      err_d = 1'b1;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      seg_s1_q      <= '1;
      seg_s2_q      <= '1;
      seg_prev_q    <= '1;
      dig_s1_q      <= '1;
      dig_s2_q      <= '1;
      dig_prev_q    <= '1;
      cnt_q         <= 8'd0;
      state_q       <= IDLE;
      mask_q        <= '0;
      digits_q      <= ALL_BLANK;
      frame_q       <= ALL_BLANK;
      frame_valid_q <= 1'b0;
      upd_q         <= 1'b0;
      upd_idx_q     <= 3'd0;
      upd_code_q    <= 4'd0;
      err_q         <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      seg_s1_q      <= seg_s1_d;
      seg_s2_q      <= seg_s2_d;
      seg_prev_q    <= seg_prev_d;
      dig_s1_q      <= dig_s1_d;
      dig_s2_q      <= dig_s2_d;
      dig_prev_q    <= dig_prev_d;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      mask_q        <= mask_d;
      digits_q      <= digits_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      upd_q         <= upd_d;
      upd_idx_q     <= upd_idx_d;
      upd_code_q    <= upd_code_d;
      err_q         <= err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign Digits      = digits_q;
  assign Frame       = frame_q;
  assign Frame_valid = frame_valid_q;
  assign Upd         = upd_q;
  assign Upd_idx     = upd_idx_q;
  assign Upd_code    = upd_code_q;
  assign Err         = err_q;
  assign Overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: directed scenarios plus randomized held/glitching patterns.
// A transaction-level model predicts each update (with its cycle) and each delivered frame.
module tb_seg7_scan_decoder;
  localparam int NDIG   = 4;
  localparam int STABLE = 8;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [0:6]  Seg;
  logic [3:0]  Dig;
  logic [15:0] Digits;
  logic        Upd;
  logic [2:0]  Upd_idx;
  logic [3:0]  Upd_code;
  logic [15:0] Frame;
  logic        Frame_valid;
  logic        Frame_ready;
  logic        Err;
  logic        Overrun;
  logic        Flag_clr;

  seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .Clock(Clock), .Resetn(Resetn), .Seg(Seg), .Dig(Dig),
    .Digits(Digits), .Upd(Upd), .Upd_idx(Upd_idx), .Upd_code(Upd_code),
    .Frame(Frame), .Frame_valid(Frame_valid), .Frame_ready(Frame_ready),
    .Err(Err), .Overrun(Overrun), .Flag_clr(Flag_clr)
  );

  always #5 Clock = ~Clock;

  int unsigned cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  idx;
    logic [3:0]  code;
    int unsigned at;
  } upd_t;

  upd_t        upd_q[$];
  logic [15:0] frame_q[$];
  int          tests = 0;
  int          fails = 0;

  // Reference tables straight from the decode rules: a..g strings and their codes.
  logic [6:0] pat_tab[12] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                              7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1111111};
  logic [3:0] code_tab[12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hE};

  logic [3:0] ref_dig[NDIG];
  logic [3:0] ref_mask;
  bit         model_fv, rdy_always, ref_err, ref_ovr;
  logic [3:0] cur_d;
  logic [6:0] cur_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] decode(input logic [6:0] s);
    for (int k = 0; k < 12; k++) if (s == pat_tab[k]) return code_tab[k];
    return 4'hF;
  endfunction

  function automatic int low_pos(input logic [3:0] d);
    if ($countones(~d) != 1) return -1;
    for (int k = 0; k < NDIG; k++) if (!d[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDIG; k++) ref_dig[k] = 4'hE;
    ref_mask = 4'b0;
    model_fv = 1'b0;
    ref_err  = 1'b0;
    ref_ovr  = 1'b0;
  endtask

  task automatic model_capture(input int idx, input logic [3:0] code, input int unsigned at);
    upd_t        u;
    logic [15:0] f;
    u.idx  = 3'(idx);
    u.code = code;
    u.at   = at;
    upd_q.push_back(u);
    ref_dig[idx]  = code;
    ref_mask[idx] = 1'b1;
    if (code == 4'hF) ref_err = 1'b1;
    if (&ref_mask) begin
      ref_mask = 4'b0;
      if (!model_fv || rdy_always) begin
        for (int k = 0; k < NDIG; k++) f[4*k +: 4] = ref_dig[k];
        frame_q.push_back(f);
        model_fv = 1'b1;
      end else begin
        ref_ovr = 1'b1;
      end
    end
  endtask

  // Present {d,s} for n sampling edges; a capture is due only if the pattern survives STABLE+1 edges.
  task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
    int unsigned e;
    int          p;
    @(posedge Clock);
    #1;
    Dig   = d;
    Seg   = s;
    e     = cyc + 1;
    p     = low_pos(d);
    if ({d, s} != {cur_d, cur_s} && n >= STABLE + 1 && p >= 0)
      model_capture(p, decode(s), e + STABLE + 2);
    cur_d = d;
    cur_s = s;
    repeat (n - 1) @(posedge Clock);
  endtask

  task automatic pulse_flag_clr();
    @(posedge Clock); #1; Flag_clr = 1'b1;
    @(posedge Clock); #1; Flag_clr = 1'b0;
    ref_err = 1'b0;
    ref_ovr = 1'b0;
  endtask

  upd_t        mon_u;
  logic [15:0] mon_f;
  always @(negedge Clock) begin
    if (Resetn && Upd) begin
      if (upd_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL upd_unexpected: got idx %0d code %0h at cycle %0d, expected no update", Upd_idx, Upd_code, cyc);
      end else begin
        mon_u = upd_q.pop_front();
        $display("[TB] upd idx=%0d code=%0h cycle=%0d", Upd_idx, Upd_code, cyc);
        chk("upd_idx", 32'(Upd_idx), 32'(mon_u.idx));
        chk("upd_code", 32'(Upd_code), 32'(mon_u.code));
        chk("upd_cycle", cyc, mon_u.at);
      end
    end
    if (Resetn && Frame_valid && Frame_ready) begin
      if (frame_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL frame_unexpected: got %h at cycle %0d, expected no frame", Frame, cyc);
      end else begin
        mon_f = frame_q.pop_front();
        $display("[TB] frame %h accepted cycle=%0d", Frame, cyc);
        chk("frame_data", 32'(Frame), 32'(mon_f));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  d;
    logic [6:0]  s;
    int unsigned e;
    int          a, b, r;

    Seg = 7'b1111111;
    Dig = 4'b1111;
    Frame_ready = 1'b0;
    Flag_clr = 1'b0;
    cur_d = 4'b1111;
    cur_s = 7'b1111111;
    rdy_always = 1'b0;
    model_reset();

    // Reset values and an idle bus.
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_digits", 32'(Digits), 32'h0000EEEE);
    chk("rst_frame", 32'(Frame), 32'h0000EEEE);
    chk("rst_upd", 32'(Upd), 0);
    chk("rst_upd_idx", 32'(Upd_idx), 0);
    chk("rst_upd_code", 32'(Upd_code), 0);
    chk("rst_fv", 32'(Frame_valid), 0);
    chk("rst_err", 32'(Err), 0);
    chk("rst_ovr", 32'(Overrun), 0);
    @(negedge Clock);
    Resetn = 1'b1;
    repeat (10) @(posedge Clock);
    @(negedge Clock);
    chk("idle_digits", 32'(Digits), 32'h0000EEEE);
    chk("idle_fv", 32'(Frame_valid), 0);

    // Single capture on position 0.
    hold(4'b1110, 7'b0010010, 12);
    @(negedge Clock);
    chk("single_digit0", 32'(Digits[3:0]), 32'h2);

    // Full scan with the consumer stalled.
    hold(4'b1110, 7'b1001111, 10);
    hold(4'b1101, 7'b0000100, 10);
    hold(4'b1011, 7'b0001000, 10);
    hold(4'b0111, 7'b0000001, 10);
    repeat (4) @(posedge Clock);
    @(negedge Clock);
    chk("scan_frame", 32'(Frame), 32'h00000A91);
    chk("scan_fv", 32'(Frame_valid), 1);
    chk("scan_ovr", 32'(Overrun), 32'(ref_ovr));

    // Second scan while the first frame is still pending.
    hold(4'b1110, 7'b0100100, 10);
    hold(4'b1101, 7'b0100000, 10);
    hold(4'b1011, 7'b0001111, 10);
    hold(4'b0111, 7'b0000000, 10);
    repeat (4) @(posedge Clock);
    @(negedge Clock);
    chk("overrun_set", 32'(Overrun), 32'(ref_ovr));
    chk("overrun_frame_kept", 32'(Frame), 32'h00000A91);
    chk("overrun_fv", 32'(Frame_valid), 1);

    @(posedge Clock); #1; Frame_ready = 1'b1; model_fv = 1'b0;
    @(posedge Clock); #1; Frame_ready = 1'b0;
    @(negedge Clock);
    chk("accept_fv_drop", 32'(Frame_valid), 0);
    pulse_flag_clr();
    @(negedge Clock);
    chk("ovr_cleared", 32'(Overrun), 32'(ref_ovr));

    // Illegal segment pattern, then a two-hot digit enable.
    hold(4'b1110, 7'b1111110, 10);
    repeat (4) @(posedge Clock);
    @(negedge Clock);
    chk("illegal_err", 32'(Err), 32'(ref_err));
    hold(4'b1100, 7'b0000001, 14);
    @(negedge Clock);
    chk("twohot_digits", 32'(Digits), {16'h0, ref_dig[3], ref_dig[2], ref_dig[1], ref_dig[0]});
    pulse_flag_clr();
    @(negedge Clock);
    chk("err_cleared", 32'(Err), 32'(ref_err));

    // Glitch in the middle of a hold restarts the window.
    hold(4'b1011, 7'b0000110, 5);
    hold(4'b1011, 7'b1001100, 1);
    hold(4'b1011, 7'b0000110, 12);
    @(negedge Clock);

    // Reset while settling at cnt=5.
    @(posedge Clock); #1;
    Dig = 4'b1101;
    Seg = 7'b0100100;
    cur_d = Dig;
    cur_s = 7'b0100100;
    e = cyc + 1;
    while (cyc < e + 7) @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b0;
    #1;
    model_reset();
    chk("midrst_digits", 32'(Digits), 32'h0000EEEE);
    chk("midrst_frame", 32'(Frame), 32'h0000EEEE);
    chk("midrst_upd", 32'(Upd), 0);
    chk("midrst_fv", 32'(Frame_valid), 0);
    chk("midrst_err", 32'(Err), 0);
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    model_capture(1, 4'h5, cyc + 1 + STABLE + 2);
    repeat (STABLE + 5) @(posedge Clock);
    @(negedge Clock);
    chk("midrst_recapture", 32'(Digits[7:4]), 32'(ref_dig[1]));

    // Randomized holds with the consumer always ready.
    rdy_always = 1'b1;
    Frame_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      do begin
        r = int'($urandom_range(0, 9));
        a = int'($urandom_range(0, NDIG - 1));
        if (r < 7) d = ~(4'b1 << a);
        else if (r == 7) d = 4'b1111;
        else begin
          b = (a + int'($urandom_range(1, NDIG - 1))) % NDIG;
          d = ~((4'b1 << a) | (4'b1 << b));
        end
        r = int'($urandom_range(0, 13));
        if (r < 11) s = pat_tab[r];
        else if (r == 11) s = 7'b1111111;
        else s = 7'($urandom);
      end while ({d, s} == {cur_d, cur_s});
      hold(d, s, int'($urandom_range(1, STABLE + 4)));
    end
    hold(4'b1111, 7'b1111111, STABLE + 6);
    @(negedge Clock);
    chk("drain_upd", 32'(upd_q.size()), 0);
    chk("drain_frame", 32'(frame_q.size()), 0);
    chk("rand_err", 32'(Err), 32'(ref_err));
    chk("rand_ovr", 32'(Overrun), 32'(ref_ovr));
    chk("rand_digits", 32'(Digits), {16'h0, ref_dig[3], ref_dig[2], ref_dig[1], ref_dig[0]});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Reads a multiplexed, active-low seven-segment display bus (segments a..g plus per-digit enables) and recovers the 4-bit digit code shown on each position. It is the reading end of the segment bus that our BCD-to-segment decoders drive. Typical uses are self-checking of display paths and snooping an external display. Inputs are synchronised and debounced, the pattern is reverse-decoded, and a complete frame of all digits is delivered over a valid/ready handshake.

Parameters:
NDIG, 4, number of multiplexed digit positions (1..8).
STABLE, 8, consecutive cycles that {Dig,Seg} must hold before a capture (2..255).

Ports:
Clock  input  1  system clock, rising edge.
Resetn  input  1  asynchronous active-low reset.
Seg  input  [0:6]  segment lines a..g; Seg[0]=a, Seg[6]=g; active-low (0 = lit).
Dig  input  NDIG  digit enables, active-low; exactly one low selects the position.
Digits  output  4*NDIG  live per-position code; position i is at bits [4i+3:4i].
Upd  output  1  one-cycle pulse when any position is captured.
Upd_idx  output  3  position index of the current Upd.
Upd_code  output  4  code captured with the current Upd.
Frame  output  4*NDIG  snapshot taken when all positions have been refreshed.
Frame_valid  output  1  Frame is held and valid.
Frame_ready  input  1  consumer accepts Frame.
Err  output  1  sticky flag: an illegal pattern was captured.
Overrun  output  1  sticky flag: a frame completed while Frame_valid=1.
Flag_clr  input  1  clears Err and Overrun.

Behaviour:
- Reset (async, Resetn=0): every Digits slot = 4'hE (blank); Frame = all 4'hE; Upd=0; Upd_idx=0; Upd_code=0; Frame_valid=0; Err=0; Overrun=0.
- Reset also clears the sync flops to all-ones (idle bus), the counter, the refresh mask, and the FSM state (IDLE).
- A reset mid-settle discards the partial count.
- Synchronisation: Seg and Dig pass through two flops, giving s2. A third register holds prev = last s2.
- Stability counter cnt:
  - Cleared to 0 when s2 != prev.
  - Otherwise incremented, saturating at STABLE.
- Reverse decode of s2 Seg:
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4.
  - 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9.
  - 0001000->4'hA.
  - 1111111 -> 4'hE (blank, legal).
  - Any other pattern -> 4'hF (illegal).
- FSM states:
  - IDLE: s2 Dig is not one-hot-low (none or more than one low). No capture occurs in IDLE.
  - SETTLE: s2 Dig is one-hot-low and cnt < STABLE-1.
  - LOCKED: the capture for the current pattern is done; no further capture until s2 changes.
- Transitions:
  - Any s2 change -> SETTLE (or IDLE if Dig is not one-hot-low).
  - SETTLE -> LOCKED on the cycle cnt reaches STABLE-1.
- Capture (on the SETTLE->LOCKED edge):
  - The Digits slot is written.
  - Upd=1 for exactly one cycle, with Upd_idx and Upd_code.
  - The slot's bit is set in the refresh mask.
  - Err is set if the code is 4'hF.
- Latency: for inputs first sampled at edge E and held, the capture is registered at edge E+STABLE+2.
- Frame completion (refresh mask all ones, including the capture cycle itself):
  - If Frame_valid=0: Frame <= Digits including the new capture; Frame_valid=1 on the next cycle; mask cleared.
  - If Frame_valid=1: Frame is unchanged; Overrun set; mask cleared.
- Handshake:
  - Frame_valid and Frame stay stable until a cycle with Frame_valid & Frame_ready, after which Frame_valid drops next edge.
  - If completion and accept occur in the same cycle, the new frame loads and Frame_valid stays 1; no Overrun.
- Flag_clr: clears Err and Overrun next edge. A simultaneous set wins.
- Width rules: Upd_idx is zero-extended to 3 bits. Dig bits above NDIG do not exist.

Test Plan:
- Reset then idle bus (Seg=1111111, Dig all 1) -> Digits=16'hEEEE, Frame_valid=0, Upd never pulses.
- Dig=4'b1110, Seg=0010010 held 12 cycles -> exactly one Upd at edge E+10 (STABLE=8), Upd_idx=0, Upd_code=2; Digits[3:0]=2.
- Scan positions 0..3 with 1,9,A,0 (patterns 1001111, 0000100, 0001000, 0000001), each held 10 cycles, Frame_ready=0 -> Frame=16'h0A91 and Frame_valid=1. Second full scan -> Overrun=1, Frame unchanged. Assert Frame_ready -> Frame_valid drops.
- Glitch: pattern held 5 cycles, toggled 1 cycle, held again -> no Upd until STABLE+2 after the final change.
- Illegal pattern 1111110, or Dig=4'b1100 -> Upd_code=F with Err=1 in the first case. For Dig=4'b1100, no Upd and the FSM stays in IDLE. Flag_clr clears Err.
- Assert Resetn=0 mid-SETTLE at cnt=5 -> all outputs return to reset values immediately; no capture after release until a full STABLE window.
